mem_access_controller: RTL
==========================

Name: mem_access_controller

Overview:
Sequential initiator that drives the 8x8 bit-memory array (eight word cells, each with sel/rw/wordIn/wordOut) from a host-side valid/ready request channel. It converts each accepted read or write request into a timed array access sequence: setup, select strobe, hold. It captures read data and returns a response on a valid/ready response channel. It sits between host logic and the array, one transaction in flight.

Parameters:
ADDR_W, 3, word address width; array depth NUM_WORDS = 2**ADDR_W (8).
DATA_W, 8, word width; matches array wordIn/wordOut.
STROBE_CYCLES, 1, cycles mem_sel is held asserted per access (legal 1..15).

Ports:
clk  input  1  single clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  host request valid.
req_ready  output  1  controller can accept a request.
req_we  input  1  1 = write, 0 = read.
req_addr  input  ADDR_W  target word index.
req_wdata  input  DATA_W  write data.
rsp_valid  output  1  response valid.
rsp_ready  input  1  host accepts response.
rsp_we  output  1  echo of request type.
rsp_rdata  output  DATA_W  read data (0 for writes).
busy  output  1  high in any state other than IDLE.
mem_sel  output  NUM_WORDS  one-hot word select to array, bit i to word cell i.
mem_rw  output  1  array direction, 1 = write, 0 = read.
mem_word_in  output  DATA_W  data to all word cells.
mem_word_out  input  DATA_W  muxed read data from array.

Behaviour:
- Reset (async assert, sync to clk on release): state=IDLE. req_ready=1 after reset release. Output values while reset is asserted: rsp_valid=0, rsp_we=0, rsp_rdata=0, busy=0, mem_sel=0, mem_rw=0, mem_word_in=0, strobe counter=0, request latches cleared.
- FSM states: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE: req_ready=1, all mem_* outputs 0.
  - On req_valid&&req_ready: latch req_we/req_addr/req_wdata, go to SETUP.
  - Request inputs are ignored in every other state.
- SETUP (1 cycle):
  - mem_rw=latched we.
  - mem_word_in=latched wdata if write, else 0.
  - mem_sel=0.
- STROBE (STROBE_CYCLES cycles):
  - mem_sel=1<<addr; mem_rw/mem_word_in held.
  - Counter counts 0..STROBE_CYCLES-1, then go to HOLD.
  - Read: rsp_rdata register loads mem_word_out on the last STROBE cycle edge.
- HOLD (1 cycle):
  - mem_sel=0; mem_rw/mem_word_in still held.
  - Guarantees no data/direction change while any select is high.
- RESP: mem_* return to 0.
  - rsp_valid=1, rsp_we=latched we, rsp_rdata=captured data for reads, 0 for writes.
  - Remain in RESP with outputs stable until rsp_ready=1. On rsp_valid&&rsp_ready go to IDLE, and rsp_valid drops the next cycle.
- Latency: accept edge at cycle 0 gives SETUP at cycle 1, STROBE at cycles 2..1+S, HOLD at 2+S, rsp_valid at 3+S (S=1 gives cycle 4). Minimum request-to-request spacing is 4+S cycles with rsp_ready tied high.
- Invariants:
  - mem_sel is zero or one-hot at all times.
  - mem_sel is never asserted in SETUP/HOLD/RESP/IDLE.
  - mem_rw changes only when mem_sel=0.
- Address is ADDR_W bits covering exactly NUM_WORDS, so no out-of-range case exists.
- Reset mid-operation (any state): mem_sel drops to 0 immediately (async). Transaction is discarded and no response is issued.
- rsp_ready held high before a response exists has no effect.

Test Plan:
- Write addr 3 data 0xA5, then read addr 3 (rsp_ready=1) -> mem_sel=0x08 for 1 cycle each access, mem_rw=1 then 0, read rsp_rdata=0xA5 with rsp_valid at cycle 4 after accept.
- Walk writes addr 0..7 with data 0x10+i, then read all -> each mem_sel equals 1<<i, reads return 0x10..0x17 in order, mem_sel never multi-hot.
- Hold rsp_ready=0 for 5 cycles after read of 0x3C -> rsp_valid/rsp_rdata=0x3C stable, req_ready=0, new req_valid ignored; response releases one cycle after rsp_ready=1.
- STROBE_CYCLES=3, write addr 6 data 0xFF -> mem_sel=0x40 for exactly 3 cycles; mem_rw and mem_word_in stable from SETUP through HOLD; rsp_valid at cycle 6.
- Assert rst_n=0 during STROBE of a write -> mem_sel=0 in the same cycle, no rsp_valid after release, req_ready=1 on the first cycle after release.
- req_valid held continuously with alternating write/read requests -> one accept per 5 cycles (S=1), busy high between accept and response handshake, responses in request order.

Source files
------------

// File: rtl/mem_access_controller.sv
// mem_access_controller
//   Sequential initiator for an 8x8 bit-memory array. Accepts one host
//   request at a time on a valid/ready channel and turns it into a timed
//   array access: SETUP (direction/data driven, no select), STROBE
//   (one-hot select for STROBE_CYCLES cycles), HOLD (select dropped,
//   direction/data still held). It then presents the result on a
//   valid/ready response channel.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         host request handshake
//   req_we, req_addr, req_wdata request type, word index, write data
//   rsp_valid/rsp_ready         response handshake
//   rsp_we, rsp_rdata           echoed type, read data (0 for writes)
//   busy                        high whenever the controller is not idle
//   mem_sel                     one-hot word select, bit i -> word cell i
//   mem_rw                      array direction, 1 = write
//   mem_word_in                 data to all word cells
//   mem_word_out                muxed read data from the array
module mem_access_controller #(
  parameter int ADDR_W        = 3,
  parameter int DATA_W        = 8,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_we,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     busy,
  output logic [(1<<ADDR_W)-1:0]   mem_sel,
  output logic                     mem_rw,
  output logic [DATA_W-1:0]        mem_word_in,
  input  logic [DATA_W-1:0]        mem_word_out
);

  localparam int NUM_WORDS = 1 << ADDR_W;
  localparam logic [3:0] CNT_LAST = 4'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } state_t;

  state_t              state_reg, state_next;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic [3:0]          cnt_reg;
  logic                strobe_last;
  logic [NUM_WORDS-1:0] sel_decode;

  assign strobe_last = (cnt_reg == CNT_LAST);

  // Address decode of the latched word index; only gated onto mem_sel
  // during STROBE, so the array never sees a select outside that window.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_decode
      assign sel_decode[gi] = (addr_reg == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid) begin
        we_reg    <= req_we;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        // Writes report zero data, so clear any stale read value here.
        rdata_reg <= '0;
      end
      if (state_reg == STROBE) begin
        if (strobe_last) begin
          cnt_reg <= '0;
          // Sample on the last strobe edge: the array has had the full
          // strobe window to settle its muxed output.
          if (!we_reg) begin
            rdata_reg <= mem_word_out;
          end
        end else begin
          cnt_reg <= cnt_reg + 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_we      = 1'b0;
    rsp_rdata   = '0;
    busy        = 1'b1;
    mem_sel     = '0;
    mem_rw      = 1'b0;
    mem_word_in = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        mem_rw      = we_reg;
        mem_word_in = we_reg ? wdata_reg : '0;
        state_next  = STROBE;
      end
      STROBE: begin
        mem_sel     = sel_decode;
        mem_rw      = we_reg;
        mem_word_in = we_reg ? wdata_reg : '0;
        if (strobe_last) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        // Select is already low; direction and data stay put one more
        // cycle so they never move while any word cell is selected.
        mem_rw      = we_reg;
        mem_word_in = we_reg ? wdata_reg : '0;
        state_next  = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_we    = we_reg;
        rsp_rdata = rdata_reg;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
